uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine_if.sv | 12 +
 rtl/uart_tx_engine.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_engine.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_if.sv
// Host-side write port of the UART transmitter: byte strobe, overrun clear
// and the holding-register / overrun status flags.
interface uart_tx_engine_if;
  logic       load;
  logic [7:0] din;
  logic       clr_ovr;
  logic       txrdy;
  logic       ovr;

  modport master (output load, din, clr_ovr, input txrdy, ovr);
  modport slave  (input load, din, clr_ovr, output txrdy, ovr);
endinterface

// File: rtl/uart_tx_engine.sv
// Double-buffered UART transmitter: holding register feeds a shift register,
// frames of start / 7-8 data / optional parity / stop, each bit k clocks long.
module uart_tx_engine #(
  parameter int K_W = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [K_W-1:0] k,
  input  logic           eight,
  input  logic           pen,
  input  logic           ohel,
  uart_tx_engine_if.slave hif,
  output logic           tx,
  output logic           busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e         state_q, state_d;
  logic [K_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0] k_q, k_d;
  logic [3:0]     bit_q, bit_d;
  logic [7:0]     hold_q, hold_d;
  logic [7:0]     sh_q, sh_d;
  logic           eight_q, eight_d;
  logic           pen_q, pen_d;
  logic           par_q, par_d;
  logic           tx_q, tx_d;
  logic           txrdy_q, txrdy_d;
  logic           ovr_q, ovr_d;

  logic [K_W-1:0] k_eff;
  logic [7:0]     data_sel;
  logic           bit_end, last_data, xfer, load_acc, load_rej;

  // A zero divisor would never terminate a bit; treat it as one cycle.
  assign k_eff     = (k_q == '0) ? K_W'(1) : k_q;
  assign bit_end   = (cnt_q == k_eff - K_W'(1));
  assign last_data = (bit_q == (eight_q ? 4'd7 : 4'd6));
  assign data_sel  = eight ? hold_q : {1'b0, hold_q[6:0]};

  // Holding register is full exactly when txrdy is low.
  assign xfer      = (state_q == IDLE) && !txrdy_q;
  assign load_acc  = hif.load && txrdy_q;
  assign load_rej  = hif.load && !txrdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    sh_d    = sh_q;
    eight_d = eight_q;
    pen_d   = pen_q;
    par_d   = par_q;
    tx_d    = tx_q;
    txrdy_d = txrdy_q;
    ovr_d   = ovr_q;

    if (state_q != IDLE)
      cnt_d = bit_end ? '0 : cnt_q + K_W'(1);

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (xfer) begin
          state_d = START;
          sh_d    = data_sel;
          k_d     = k;
          eight_d = eight;
          pen_d   = pen;
          par_d   = (^data_sel) ^ ohel;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          txrdy_d = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            state_d = pen_q ? PARITY : STOP;
            tx_d    = pen_q ? par_q : 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Load and transfer never coincide: load needs txrdy=1, transfer txrdy=0.
    if (load_acc) begin
      hold_d  = hif.din;
      txrdy_d = 1'b0;
    end

    if (hif.clr_ovr) ovr_d = 1'b0;
    if (load_rej)    ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      sh_q    <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      txrdy_q <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      sh_q    <= sh_d;
      eight_q <= eight_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      txrdy_q <= txrdy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign hif.txrdy = txrdy_q;
  assign hif.ovr   = ovr_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: frame vector table, hand-written corner sequences
// and a random run against a queue-of-line-levels reference model.
module tb_uart_tx_engine;
  localparam int KW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [KW-1:0] k = '0;
  logic          eight = 1'b0, pen = 1'b0, ohel = 1'b0;
  logic          tx, busy;
  logic          chk_en = 1'b0;

  uart_tx_engine_if bus();

  uart_tx_engine #(.K_W(KW)) dut (
    .clk(clk), .reset(reset), .k(k), .eight(eight), .pen(pen), .ohel(ohel),
    .hif(bus), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: one queued line level per future clock cycle.
  logic       m_wave[$];
  logic [7:0] m_hold;
  logic       m_txrdy = 1'b1;
  logic       m_ovr = 1'b0;

  function automatic void m_push(input logic [7:0] d, input int kin,
                                 input logic e, input logic p, input logic o);
    logic b[$];
    logic par;
    int   kk;
    kk  = (kin == 0) ? 1 : kin;
    par = o;
    b.push_back(1'b0);
    for (int i = 0; i < (e ? 8 : 7); i++) begin
      b.push_back(d[i]);
      par ^= d[i];
    end
    if (p) b.push_back(par);
    b.push_back(1'b1);
    foreach (b[i]) for (int c = 0; c < kk; c++) m_wave.push_back(b[i]);
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_wave.delete();
      m_txrdy = 1'b1;
      m_ovr   = 1'b0;
    end else begin
      logic was_busy, was_rdy;
      was_busy = (m_wave.size() != 0);
      was_rdy  = m_txrdy;
      if (was_busy) void'(m_wave.pop_front());
      if (!was_busy && !was_rdy) begin
        m_push(m_hold, int'(k), eight, pen, ohel);
        m_txrdy = 1'b1;
      end
      if (bus.clr_ovr) m_ovr = 1'b0;
      if (bus.load) begin
        if (was_rdy) begin
          m_hold  = bus.din;
          m_txrdy = 1'b0;
        end else m_ovr = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && !reset) begin
      chk("model_tx",    tx,        (m_wave.size() != 0) ? m_wave[0] : 1'b1);
      chk("model_busy",  busy,      m_wave.size() != 0);
      chk("model_txrdy", bus.txrdy, m_txrdy);
      chk("model_ovr",   bus.ovr,   m_ovr);
    end
  end

  task automatic do_load(input logic [7:0] d);
    @(posedge clk); #1 bus.load = 1'b1; bus.din = d;
    @(posedge clk); #1 bus.load = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    for (int w = 0; w < 8 && !busy; w++) @(negedge clk);
    chk(name, busy, 1'b1);
  endtask

  typedef struct {
    logic [KW-1:0] k;
    logic          eight, pen, ohel;
    logic [7:0]    din;
    int            nbits;
    logic [10:0]   bits;   // bit i = i-th level on the line, start bit first
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load = 1'b0; bus.din = '0; bus.clr_ovr = 1'b0;
    vecs[0] = '{k: 4, eight: 1, pen: 0, ohel: 0, din: 8'h55, nbits: 10, bits: 11'h2AA};
    vecs[1] = '{k: 2, eight: 0, pen: 1, ohel: 0, din: 8'hC3, nbits: 10, bits: 11'h386};
    vecs[2] = '{k: 0, eight: 1, pen: 1, ohel: 1, din: 8'hA5, nbits: 11, bits: 11'h74A};
    vecs[3] = '{k: 3, eight: 0, pen: 1, ohel: 1, din: 8'hFF, nbits: 10, bits: 11'h2FE};
    vecs[4] = '{k: 1, eight: 1, pen: 0, ohel: 0, din: 8'h00, nbits: 10, bits: 11'h200};

    // Reset acts without a clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_txrdy", bus.txrdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", bus.ovr, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Frame table.
    foreach (vecs[v]) begin
      int kk;
      logic ok;
      k = vecs[v].k; eight = vecs[v].eight; pen = vecs[v].pen; ohel = vecs[v].ohel;
      kk = (vecs[v].k == 0) ? 1 : int'(vecs[v].k);
      do_load(vecs[v].din);
      @(negedge clk);
      chk("vec_txrdy_low", bus.txrdy, 1'b0);
      chk("vec_not_busy_yet", busy, 1'b0);
      @(negedge clk);
      chk("vec_start", busy, 1'b1);
      chk("vec_txrdy_back", bus.txrdy, 1'b1);
      for (int i = 0; i < vecs[v].nbits; i++) begin
        ok = 1'b1;
        for (int c = 0; c < kk; c++) begin
          if (tx !== vecs[v].bits[i] || busy !== 1'b1) ok = 1'b0;
          @(negedge clk);
        end
        chk($sformatf("vec%0d_bit%0d", v, i), ok, 1'b1);
      end
      chk("vec_end_busy", busy, 1'b0);
      chk("vec_end_tx", tx, 1'b1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames and overrun.
    begin
      logic ok;
      int idle;
      k = 2; eight = 1; pen = 0; ohel = 0;
      do_load(8'h81);
      @(negedge clk);
      wait_busy("b2b_a_start");
      do_load(8'h42);
      @(negedge clk);
      chk("b2b_txrdy_low", bus.txrdy, 1'b0);
      do_load(8'hFF);
      @(negedge clk);
      chk("ovr_set", bus.ovr, 1'b1);
      ok = 1'b1;
      for (int w = 0; w < 100 && busy; w++) begin
        if (bus.txrdy !== 1'b0) ok = 1'b0;
        @(negedge clk);
      end
      chk("b2b_txrdy_held", ok, 1'b1);
      idle = 0;
      for (int w = 0; w < 10 && !busy; w++) begin
        idle++;
        @(negedge clk);
      end
      chk("b2b_idle_cycles", idle, 1);
      chk("b2b_txrdy_after_xfer", bus.txrdy, 1'b1);
      for (int w = 0; w < 100 && busy; w++) @(negedge clk);
      ok = 1'b1;
      repeat (30) begin
        if (busy !== 1'b0 || tx !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      chk("ovr_c_not_sent", ok, 1'b1);
      chk("ovr_sticky", bus.ovr, 1'b1);
      @(posedge clk); #1 bus.clr_ovr = 1'b1;
      @(posedge clk); #1 bus.clr_ovr = 1'b0;
      @(negedge clk);
      chk("ovr_clr", bus.ovr, 1'b0);
    end

    // Config change mid-frame must not affect the frame in flight.
    begin
      int len;
      k = 2; eight = 1; pen = 0; ohel = 0;
      do_load(8'h3C);
      @(negedge clk);
      wait_busy("cfg_start");
      repeat (5) @(negedge clk);
      k = 7; eight = 0; pen = 1; ohel = 1;
      len = 5;
      for (int w = 0; w < 200 && busy; w++) begin
        len++;
        @(negedge clk);
      end
      chk("cfg_frame_len", len, 20);
      repeat (3) @(negedge clk);
    end

    // Reset in the middle of data bit 3, with a byte pending and ovr set.
    begin
      logic ok;
      k = 4; eight = 1; pen = 0; ohel = 0;
      do_load(8'hA7);
      @(negedge clk);
      wait_busy("mid_start");
      do_load(8'h11);
      do_load(8'h22);
      @(negedge clk);
      chk("mid_ovr_pre", bus.ovr, 1'b1);
      repeat (13) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_txrdy", bus.txrdy, 1'b1);
      chk("mid_rst_ovr", bus.ovr, 1'b0);
      bus.load = 1'b1; bus.din = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1 bus.load = 1'b0; reset = 1'b0;
      ok = 1'b1;
      repeat (50) begin
        @(negedge clk);
        if (busy !== 1'b0 || tx !== 1'b1 || bus.txrdy !== 1'b1) ok = 1'b0;
      end
      chk("mid_no_residual", ok, 1'b1);
    end

    // Random traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      bus.load    = ($urandom_range(0, 9) == 0);
      bus.din     = 8'($urandom);
      bus.clr_ovr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) begin
        k     = KW'($urandom_range(0, 4));
        eight = 1'($urandom);
        pen   = 1'($urandom);
        ohel  = 1'($urandom);
      end
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(posedge clk); #1 bus.load = 1'b0; bus.clr_ovr = 1'b0;
    repeat (200) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
